stopwatch_bcd: RTL and testbench
================================

Name: stopwatch_bcd

Overview:
Parametrised multi-digit BCD stopwatch/countdown timer with run/pause control, lap-hold display, load and expiry, plus per-digit seven-segment decode. Sits beside the SoC's timer peripherals, driven by clk, and advanced by a single-cycle tick strobe from a prescaler. Generalises the fixed 3-digit up-counter to N digits, adds down-count mode, lap freeze, wrap/expire flags and selectable segment polarity.

Parameters:
NUM_DIGITS, 4, number of BCD digits (2..8); digit 0 is least significant.
TOP_MOD, 10, modulus of the most significant digit (2..10); all other digits are mod 10.
SEG_ACTIVE_LOW, 1, 1 = seg_o inverted (common-anode), 0 = active-high.

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
tick_i  in  1  single-cycle count strobe
mode_i  in  1  0 = count up, 1 = count down; sampled on each counted tick
start_i  in  1  start/resume strobe
stop_i  in  1  pause strobe
clear_i  in  1  synchronous clear strobe
lap_i  in  1  lap toggle strobe
load_i  in  1  load strobe
load_val_i  in  4*NUM_DIGITS  BCD preset value
count_o  out  4*NUM_DIGITS  live BCD count
disp_o  out  4*NUM_DIGITS  displayed value: lap register in LAP, else live count
seg_o  out  7*NUM_DIGITS  per-digit segments {g,f,e,d,c,b,a} of disp_o
state_o  out  3  FSM state
wrap_o  out  1  one-cycle pulse on up-count wrap
expired_o  out  1  high while in EXPIRED

Behaviour:
- Reset: state IDLE (0), count 0, lap register 0, wrap_o 0, expired_o 0. seg_o shows all "0" glyphs in the selected polarity.
- States: IDLE=0, RUN=1, PAUSE=2, LAP=3, EXPIRED=4. Other encodings are unreachable and recover to IDLE on the next clk.
- Priority each cycle: clear_i > load_i > stop_i > start_i > lap_i.
- clear_i: any state -> IDLE; count = 0, lap register = 0.
- load_i: any state -> IDLE; count = load_val_i with each digit clamped to (modulus-1) if it is out of range (e.g. 0xC -> 9; top digit clamped to TOP_MOD-1).
- IDLE: start_i -> RUN. In down mode with count == 0, start_i is ignored.
- RUN: stop_i -> PAUSE. lap_i -> LAP and captures count into the lap register.
- LAP: counting continues while disp_o holds the lap register. lap_i -> RUN (release). stop_i -> PAUSE.
- PAUSE: start_i -> RUN.
- EXPIRED: exits only via clear_i or load_i.
- stop_i and start_i in the same cycle: stop wins.
- Count enable = tick_i AND (state is RUN or LAP at the edge) AND NOT clear_i AND NOT load_i. A tick in the same cycle as start_i is not counted. A tick in the same cycle as stop_i in RUN is counted.
- Lap capture coincident with a tick stores the pre-tick value.
- Up count: ripple BCD carry. Digit i increments when all lower digits are at max. Each digit wraps max -> 0.
  - At full scale (TOP_MOD-1 followed by 9s, e.g. 9999), a tick gives 0, wrap_o = 1 for exactly that one cycle (registered, the cycle after the edge), and counting continues.
- Down count: ripple BCD borrow; 0 -> 9 (top digit 0 -> TOP_MOD-1).
  - A tick that makes count == 0 also enters EXPIRED on the same edge; expired_o = 1.
  - Ticks are ignored in EXPIRED.
- mode_i may change mid-run; the change takes effect on the next counted tick.
- Latency: count_o, disp_o, state_o update on the clk edge. seg_o is combinational from disp_o, so it is valid in the same cycle.
- Segment decode (active-high, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Values 10..15 decode to 0000000 (blank).
  - The result is inverted when SEG_ACTIVE_LOW = 1.
- Reset asserted mid-operation returns all state to reset values immediately.

Test Plan:
- Up wrap: NUM_DIGITS=4, TOP_MOD=10. Load 9998, start, 2 ticks -> count 9999 then 0000, wrap_o high for exactly 1 cycle, state stays RUN.
- Down expire: mode_i=1, load 0002, start, 3 ticks -> count 0001, then 0000 with state EXPIRED and expired_o=1. The 3rd tick leaves count 0000. start_i is then ignored; clear_i -> IDLE with expired_o=0.
- Lap: start from 0, 5 ticks, lap_i coincident with the 6th tick -> disp_o 0005 while count_o 0006. 4 more ticks -> disp_o 0005, count_o 0010. lap_i -> disp_o 0010.
- Priority/simultaneity: in RUN, assert start_i+stop_i together -> PAUSE. clear_i+load_i together -> count 0000. tick_i with start_i from IDLE -> count unchanged.
- Clamp and decode: load_val_i=0xF3A1 with TOP_MOD=6 -> count 5391. seg_o digit0 (value 1) = ~0000110 = 1111001 with SEG_ACTIVE_LOW=1.
- Async reset mid-RUN at count 0123 -> immediately IDLE, count 0000, seg_o all "0" glyphs, flags low.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// Control/status bundle for the BCD stopwatch.
// Master drives strobes and preset; slave returns count, display and flags.
interface stopwatch_bcd_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    tick_i;
   logic                    mode_i;
   logic                    start_i;
   logic                    stop_i;
   logic                    clear_i;
   logic                    lap_i;
   logic                    load_i;
   logic [4*NUM_DIGITS-1:0] load_val_i;
   logic [4*NUM_DIGITS-1:0] count_o;
   logic [4*NUM_DIGITS-1:0] disp_o;
   logic [7*NUM_DIGITS-1:0] seg_o;
   logic [2:0]              state_o;
   logic                    wrap_o;
   logic                    expired_o;

   modport master (
      output tick_i, mode_i, start_i, stop_i,
      output clear_i, lap_i, load_i, load_val_i,
      input  count_o, disp_o, seg_o, state_o,
      input  wrap_o, expired_o
   );

   modport slave (
      input  tick_i, mode_i, start_i, stop_i,
      input  clear_i, lap_i, load_i, load_val_i,
      output count_o, disp_o, seg_o, state_o,
      output wrap_o, expired_o
   );
endinterface

// File: rtl/stopwatch_bcd.sv
// N-digit BCD stopwatch / countdown timer with lap hold,
// load clamp, wrap/expire flags and seven-segment decode.
module stopwatch_bcd #(
   parameter int NUM_DIGITS     = 4,
   parameter int TOP_MOD        = 10,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input logic            clk,
   input logic            rstn,
   stopwatch_bcd_if.slave bus
);
   localparam int W = 4 * NUM_DIGITS;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      PAUSE   = 3'd2,
      LAP     = 3'd3,
      EXPIRED = 3'd4
   } state_t;

   state_t       state;
   logic [W-1:0] count;
   logic [W-1:0] lap_reg;
   logic         wrap;

   logic [W-1:0] inc_val;
   logic [W-1:0] dec_val;
   logic [W-1:0] clamp_val;
   logic         full;
   logic         count_en;
   logic         to_zero;

   function automatic logic [3:0] dmax(input int i);
      if (i == NUM_DIGITS - 1)
         return 4'(TOP_MOD - 1);
      return 4'd9;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return SEG_ACTIVE_LOW ? ~s : s;
   endfunction

   // Ripple carry/borrow across digits; carry out of the top means full scale.
   always_comb begin
      logic       cy;
      logic       bw;
      logic [3:0] d;
      inc_val   = '0;
      dec_val   = '0;
      clamp_val = '0;
      cy        = 1'b1;
      bw        = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = count[4*i +: 4];
         if (!cy)
            inc_val[4*i +: 4] = d;
         else if (d >= dmax(i))
            inc_val[4*i +: 4] = 4'd0;
         else begin
            inc_val[4*i +: 4] = d + 4'd1;
            cy = 1'b0;
         end
         if (!bw)
            dec_val[4*i +: 4] = d;
         else if (d == 4'd0)
            dec_val[4*i +: 4] = dmax(i);
         else begin
            dec_val[4*i +: 4] = d - 4'd1;
            bw = 1'b0;
         end
         d = bus.load_val_i[4*i +: 4];
         clamp_val[4*i +: 4] = (d > dmax(i)) ? dmax(i) : d;
      end
      full = cy;
   end

   assign count_en = bus.tick_i
                   & ((state == RUN) | (state == LAP))
                   & ~bus.clear_i & ~bus.load_i;
   assign to_zero  = count_en & bus.mode_i & (dec_val == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         count   <= '0;
         lap_reg <= '0;
         wrap    <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (bus.clear_i) begin
            state   <= IDLE;
            count   <= '0;
            lap_reg <= '0;
         end else if (bus.load_i) begin
            state <= IDLE;
            count <= clamp_val;
         end else begin
            if (count_en) begin
               if (bus.mode_i)
                  count <= dec_val;
               else begin
                  count <= inc_val;
                  wrap  <= full;
               end
            end
            unique case (state)
               IDLE:
                  if (bus.start_i && !(bus.mode_i && count == '0))
                     state <= RUN;
               RUN:
                  if (bus.stop_i)
                     state <= PAUSE;
                  else if (bus.lap_i) begin
                     state   <= LAP;
                     lap_reg <= count;
                  end
               LAP:
                  if (bus.stop_i)
                     state <= PAUSE;
                  else if (bus.lap_i)
                     state <= RUN;
               PAUSE:
                  if (bus.start_i && !bus.stop_i)
                     state <= RUN;
               EXPIRED: state <= EXPIRED;
               default: state <= IDLE;
            endcase
            // Reaching zero while counting down overrides any other move.
            if (to_zero)
               state <= EXPIRED;
         end
      end
   end

   assign bus.count_o   = count;
   assign bus.disp_o    = (state == LAP) ? lap_reg : count;
   assign bus.state_o   = state;
   assign bus.wrap_o    = wrap;
   assign bus.expired_o = (state == EXPIRED);

   always_comb begin
      bus.seg_o = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         bus.seg_o[7*i +: 7] = seg7(bus.disp_o[4*i +: 4]);
   end
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: wrap, expire, lap,
// priority, clamp/decode and async reset.
module tb_stopwatch_bcd;
   logic clk;
   logic rstn;
   int   n_tests;
   int   n_fail;

   stopwatch_bcd_if #(.NUM_DIGITS(4)) bus ();
   stopwatch_bcd_if #(.NUM_DIGITS(4)) bus6 ();

   stopwatch_bcd #(
      .NUM_DIGITS(4), .TOP_MOD(10), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus)
   );

   stopwatch_bcd #(
      .NUM_DIGITS(4), .TOP_MOD(6), .SEG_ACTIVE_LOW(1'b1)
   ) dut6 (
      .clk(clk), .rstn(rstn), .bus(bus6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.tick_i     = 0;
      bus.start_i    = 0;
      bus.stop_i     = 0;
      bus.clear_i    = 0;
      bus.lap_i      = 0;
      bus.load_i     = 0;
      bus6.tick_i    = 0;
      bus6.start_i   = 0;
      bus6.stop_i    = 0;
      bus6.clear_i   = 0;
      bus6.lap_i     = 0;
      bus6.load_i    = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_i = 1;
         step();
      end
   endtask

   task automatic test_reset();
      rstn = 0;
      bus.mode_i = 0;
      bus.load_val_i = '0;
      bus6.mode_i = 0;
      bus6.load_val_i = '0;
      idle_inputs();
      #12;
      n_tests++;
      if (bus.state_o !== 3'd0 || bus.count_o !== 16'h0000) begin
         $display("FAIL reset_state state=%0d count=%h exp 0/0000",
                  bus.state_o, bus.count_o);
         n_fail++;
      end
      n_tests++;
      if (bus.seg_o !== {4{7'b1000000}} || bus.disp_o !== 16'h0) begin
         $display("FAIL reset_seg seg=%b exp=%b",
                  bus.seg_o, {4{7'b1000000}});
         n_fail++;
      end
      n_tests++;
      if (bus.wrap_o !== 1'b0 || bus.expired_o !== 1'b0) begin
         $display("FAIL reset_flags wrap=%b exp_o=%b exp 0/0",
                  bus.wrap_o, bus.expired_o);
         n_fail++;
      end
      @(negedge clk);
      rstn = 1;
      step();
   endtask

   task automatic test_up_wrap();
      bus.mode_i = 0;
      bus.load_val_i = 16'h9998;
      bus.load_i = 1;
      step();
      bus.start_i = 1;
      step();
      ticks(1);
      n_tests++;
      if (bus.count_o !== 16'h9999 || bus.wrap_o !== 1'b0) begin
         $display("FAIL up_9999 count=%h wrap=%b exp 9999/0",
                  bus.count_o, bus.wrap_o);
         n_fail++;
      end
      ticks(1);
      n_tests++;
      if (bus.count_o !== 16'h0000 || bus.wrap_o !== 1'b1 ||
          bus.state_o !== 3'd1) begin
         $display("FAIL up_wrap count=%h wrap=%b st=%0d exp 0000/1/1",
                  bus.count_o, bus.wrap_o, bus.state_o);
         n_fail++;
      end
      step();
      n_tests++;
      if (bus.wrap_o !== 1'b0 || bus.state_o !== 3'd1) begin
         $display("FAIL wrap_pulse wrap=%b st=%0d exp 0/1",
                  bus.wrap_o, bus.state_o);
         n_fail++;
      end
   endtask

   task automatic test_down_expire();
      bus.mode_i = 1;
      bus.load_val_i = 16'h0002;
      bus.load_i = 1;
      step();
      bus.start_i = 1;
      step();
      ticks(1);
      n_tests++;
      if (bus.count_o !== 16'h0001 || bus.state_o !== 3'd1) begin
         $display("FAIL down_1 count=%h st=%0d exp 0001/1",
                  bus.count_o, bus.state_o);
         n_fail++;
      end
      ticks(1);
      n_tests++;
      if (bus.count_o !== 16'h0000 || bus.state_o !== 3'd4 ||
          bus.expired_o !== 1'b1) begin
         $display("FAIL down_expire count=%h st=%0d ex=%b exp 0000/4/1",
                  bus.count_o, bus.state_o, bus.expired_o);
         n_fail++;
      end
      ticks(1);
      n_tests++;
      if (bus.count_o !== 16'h0000 || bus.state_o !== 3'd4) begin
         $display("FAIL expired_tick count=%h st=%0d exp 0000/4",
                  bus.count_o, bus.state_o);
         n_fail++;
      end
      bus.start_i = 1;
      step();
      n_tests++;
      if (bus.state_o !== 3'd4) begin
         $display("FAIL expired_start st=%0d exp 4", bus.state_o);
         n_fail++;
      end
      bus.clear_i = 1;
      step();
      n_tests++;
      if (bus.state_o !== 3'd0 || bus.expired_o !== 1'b0) begin
         $display("FAIL expired_clear st=%0d ex=%b exp 0/0",
                  bus.state_o, bus.expired_o);
         n_fail++;
      end
      bus.start_i = 1;
      step();
      n_tests++;
      if (bus.state_o !== 3'd0) begin
         $display("FAIL down_zero_start st=%0d exp 0", bus.state_o);
         n_fail++;
      end
      bus.mode_i = 0;
   endtask

   task automatic test_lap();
      bus.clear_i = 1;
      step();
      bus.start_i = 1;
      step();
      ticks(5);
      bus.tick_i = 1;
      bus.lap_i = 1;
      step();
      n_tests++;
      if (bus.disp_o !== 16'h0005 || bus.count_o !== 16'h0006 ||
          bus.state_o !== 3'd3) begin
         $display("FAIL lap_capture disp=%h count=%h st=%0d exp 0005/0006/3",
                  bus.disp_o, bus.count_o, bus.state_o);
         n_fail++;
      end
      ticks(4);
      n_tests++;
      if (bus.disp_o !== 16'h0005 || bus.count_o !== 16'h0010) begin
         $display("FAIL lap_hold disp=%h count=%h exp 0005/0010",
                  bus.disp_o, bus.count_o);
         n_fail++;
      end
      n_tests++;
      if (bus.seg_o[6:0] !== 7'b0010010) begin
         $display("FAIL lap_seg seg0=%b exp 0010010", bus.seg_o[6:0]);
         n_fail++;
      end
      bus.lap_i = 1;
      step();
      n_tests++;
      if (bus.disp_o !== 16'h0010 || bus.state_o !== 3'd1) begin
         $display("FAIL lap_release disp=%h st=%0d exp 0010/1",
                  bus.disp_o, bus.state_o);
         n_fail++;
      end
   endtask

   task automatic test_priority();
      bus.mode_i = 1;
      ticks(1);
      n_tests++;
      if (bus.count_o !== 16'h0009) begin
         $display("FAIL mode_switch count=%h exp 0009", bus.count_o);
         n_fail++;
      end
      bus.mode_i = 0;
      bus.start_i = 1;
      bus.stop_i = 1;
      step();
      n_tests++;
      if (bus.state_o !== 3'd2) begin
         $display("FAIL start_stop st=%0d exp 2", bus.state_o);
         n_fail++;
      end
      bus.clear_i = 1;
      bus.load_i = 1;
      bus.load_val_i = 16'h1234;
      step();
      n_tests++;
      if (bus.count_o !== 16'h0000 || bus.state_o !== 3'd0) begin
         $display("FAIL clear_load count=%h st=%0d exp 0000/0",
                  bus.count_o, bus.state_o);
         n_fail++;
      end
      bus.start_i = 1;
      bus.tick_i = 1;
      step();
      n_tests++;
      if (bus.count_o !== 16'h0000 || bus.state_o !== 3'd1) begin
         $display("FAIL tick_start count=%h st=%0d exp 0000/1",
                  bus.count_o, bus.state_o);
         n_fail++;
      end
      bus.stop_i = 1;
      bus.tick_i = 1;
      step();
      n_tests++;
      if (bus.count_o !== 16'h0001 || bus.state_o !== 3'd2) begin
         $display("FAIL tick_stop count=%h st=%0d exp 0001/2",
                  bus.count_o, bus.state_o);
         n_fail++;
      end
      ticks(1);
      n_tests++;
      if (bus.count_o !== 16'h0001) begin
         $display("FAIL pause_tick count=%h exp 0001", bus.count_o);
         n_fail++;
      end
   endtask

   task automatic test_clamp();
      bus6.load_val_i = 16'hF3A1;
      bus6.load_i = 1;
      bus.load_val_i = 16'hF3A1;
      bus.load_i = 1;
      step();
      n_tests++;
      if (bus6.count_o !== 16'h5391) begin
         $display("FAIL clamp_top6 count=%h exp 5391", bus6.count_o);
         n_fail++;
      end
      n_tests++;
      if (bus.count_o !== 16'h9391) begin
         $display("FAIL clamp_top10 count=%h exp 9391", bus.count_o);
         n_fail++;
      end
      n_tests++;
      if (bus6.seg_o !== {7'b0010010, 7'b0110000,
                          7'b0010000, 7'b1111001}) begin
         $display("FAIL seg_decode seg=%b exp %b", bus6.seg_o,
                  {7'b0010010, 7'b0110000, 7'b0010000, 7'b1111001});
         n_fail++;
      end
   endtask

   task automatic test_async_reset();
      bus.mode_i = 0;
      bus.load_val_i = 16'h0120;
      bus.load_i = 1;
      step();
      bus.start_i = 1;
      step();
      ticks(3);
      n_tests++;
      if (bus.count_o !== 16'h0123 || bus.state_o !== 3'd1) begin
         $display("FAIL pre_reset count=%h st=%0d exp 0123/1",
                  bus.count_o, bus.state_o);
         n_fail++;
      end
      bus.tick_i = 1;
      #2;
      rstn = 0;
      #1;
      n_tests++;
      if (bus.state_o !== 3'd0 || bus.count_o !== 16'h0000 ||
          bus.seg_o !== {4{7'b1000000}} ||
          bus.wrap_o !== 1'b0 || bus.expired_o !== 1'b0) begin
         $display("FAIL async_reset st=%0d count=%h seg=%b w=%b e=%b",
                  bus.state_o, bus.count_o, bus.seg_o,
                  bus.wrap_o, bus.expired_o);
         n_fail++;
      end
      idle_inputs();
      @(negedge clk);
      rstn = 1;
      step();
      n_tests++;
      if (bus.state_o !== 3'd0 || bus.count_o !== 16'h0000) begin
         $display("FAIL post_reset st=%0d count=%h exp 0/0000",
                  bus.state_o, bus.count_o);
         n_fail++;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_up_wrap();
      test_down_expire();
      test_lap();
      test_priority();
      test_clamp();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
